// File: rtl/pdcch_pn_seq_gen.sv
// PDCCH DMRS pseudo-random sequence generator.
// Takes one config (C_init, length, offset) per occasion, runs the length-31
// Gold sequence through its Nc warm-up plus the DMRS offset, then streams
// c(n) packed OUT_W bits per word (earliest bit in the LSB) to the mapper.
module pdcch_pn_seq_gen #(
  parameter int OUT_W = 2,
  parameter int NC    = 1600,
  parameter int LEN_W = 16,
  parameter int OFS_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_cfg_valid,
  output logic             s_cfg_ready,
  input  logic [30:0]      s_cfg_cinit,
  input  logic [LEN_W-1:0] s_cfg_seqlen,
  input  logic [OFS_W-1:0] s_cfg_offset,
  output logic             m_pn_valid,
  input  logic             m_pn_ready,
  output logic [OUT_W-1:0] m_pn_data,
  output logic             m_pn_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WARM, LOAD, OUT} state_t;

  state_t             r_state, w_next;
  logic               r_ready;
  logic               r_valid;
  logic               r_last;
  logic [OUT_W-1:0]   r_data;
  logic [30:0]        r_x1, r_x2;
  logic [LEN_W-1:0]   r_remaining;   // bits not yet packed into a word
  logic [16:0]        r_skip;

  logic               w_accept, w_start, w_hs, w_gen;
  logic [16:0]        w_skip0;
  logic [30:0]        w_x1, w_x2;
  logic [OUT_W-1:0]   w_word;

  function automatic logic [30:0] x1_step(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  assign w_accept = s_cfg_valid && r_ready;
  assign w_start  = w_accept && (s_cfg_seqlen != '0);
  assign w_skip0  = 17'(NC) + 17'(s_cfg_offset);
  assign w_hs     = (r_state == OUT) && r_valid && m_pn_ready;
  // A new word is built in LOAD and on every non-final handshake (no bubble).
  assign w_gen    = (r_state == LOAD) || (w_hs && !r_last);

  // Pack the next OUT_W sequence bits; bits past the end of the sequence are 0.
  always_comb begin
    w_x1   = r_x1;
    w_x2   = r_x2;
    w_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (LEN_W'(i) < r_remaining) w_word[i] = w_x1[0] ^ w_x2[0];
      w_x1 = x1_step(w_x1);
      w_x2 = x2_step(w_x2);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a zero-length config is consumed without leaving IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = (w_skip0 == '0) ? LOAD : WARM;
      WARM: if (r_skip <= 17'd1) w_next = LOAD;
      LOAD: w_next = OUT;
      OUT:  if (w_hs && r_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Config ready follows the state we are about to be in, so it is 0 out of
  // reset and rises one clock later, and reopens right after the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ready <= 1'b0;
    else        r_ready <= (w_next == IDLE);
  end

  // LFSRs, counters and the output word register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x1        <= '0;
      r_x2        <= '0;
      r_remaining <= '0;
      r_skip      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_x1        <= 31'h1;
            r_x2        <= s_cfg_cinit;
            r_remaining <= s_cfg_seqlen;
            r_skip      <= w_skip0;
          end
        end
        WARM: begin
          r_x1   <= x1_step(r_x1);
          r_x2   <= x2_step(r_x2);
          r_skip <= r_skip - 17'd1;
        end
        default: begin
          if (w_gen) begin
            r_x1        <= w_x1;
            r_x2        <= w_x2;
            r_data      <= w_word;
            r_valid     <= 1'b1;
            r_last      <= (r_remaining <= LEN_W'(OUT_W));
            r_remaining <= (r_remaining > LEN_W'(OUT_W)) ?
                           r_remaining - LEN_W'(OUT_W) : '0;
          end else if (w_hs && r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign s_cfg_ready = r_ready;
  assign m_pn_valid  = r_valid;
  assign m_pn_data   = r_data;
  assign m_pn_last   = r_last;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_pdcch_pn_seq_gen.sv
// Directed bench for pdcch_pn_seq_gen. DUT built with NC=0; the 38.211 Nc=1600
// warm-up is reproduced through the offset field (skip = NC + offset).
module tb_pdcch_pn_seq_gen;
  localparam int OUT_W = 2;
  localparam int LEN_W = 16;
  localparam int OFS_W = 13;
  localparam int NMAX  = 1800;
  localparam int LIMIT = 6000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             s_cfg_valid = 1'b0;
  logic             s_cfg_ready;
  logic [30:0]      s_cfg_cinit = '0;
  logic [LEN_W-1:0] s_cfg_seqlen = '0;
  logic [OFS_W-1:0] s_cfg_offset = '0;
  logic             m_pn_valid;
  logic             m_pn_ready = 1'b1;
  logic [OUT_W-1:0] m_pn_data;
  logic             m_pn_last;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  bit               x1 [0:NMAX+30];
  bit               x2 [0:NMAX+30];
  bit               c_seq [0:NMAX-1];
  logic [OUT_W-1:0] rx     [0:63];
  logic [OUT_W-1:0] rx_ref [0:63];

  pdcch_pn_seq_gen #(.OUT_W(OUT_W), .NC(0), .LEN_W(LEN_W), .OFS_W(OFS_W)) dut (
    .clk(clk), .reset(reset),
    .s_cfg_valid(s_cfg_valid), .s_cfg_ready(s_cfg_ready),
    .s_cfg_cinit(s_cfg_cinit), .s_cfg_seqlen(s_cfg_seqlen), .s_cfg_offset(s_cfg_offset),
    .m_pn_valid(m_pn_valid), .m_pn_ready(m_pn_ready), .m_pn_data(m_pn_data),
    .m_pn_last(m_pn_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Gold sequence straight from the recurrence definitions.
  task automatic build_model(input logic [30:0] ci);
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = ci[n];
    end
    for (int n = 0; n < NMAX; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
      c_seq[n] = x1[n] ^ x2[n];
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_word(input int base, input int k, input int len);
    logic [OUT_W-1:0] w = '0;
    for (int i = 0; i < OUT_W; i++)
      if (k*OUT_W + i < len) w[i] = c_seq[base + k*OUT_W + i];
    return w;
  endfunction

  // Present a config once ready is high; returns just after the accepting edge.
  task automatic send_cfg(input logic [30:0] ci, input int len, input int ofs);
    int t = 0;
    @(negedge clk);
    while (!s_cfg_ready && t < 100) begin @(negedge clk); t++; end
    chk("cfg_ready_wait", s_cfg_ready, 1);
    s_cfg_valid  = 1'b1;
    s_cfg_cinit  = ci;
    s_cfg_seqlen = LEN_W'(len);
    s_cfg_offset = OFS_W'(ofs);
    @(posedge clk);
    #1 s_cfg_valid = 1'b0;
  endtask

  // Receive words; cycle 1 is the cycle after the accepting edge.
  task automatic collect(input int nw, input int len, input int base, input bit rnd,
                         input int stop_at, output int first);
    int cyc = 0, widx = 0, nlast = 0, goal;
    bit stalled = 0, rdy;
    logic [OUT_W-1:0] held = '0;
    goal  = (stop_at >= 0) ? stop_at : nw;
    first = -1;
    m_pn_ready = 1'b1;
    while (widx < goal && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_after_accept", busy, 1);
        chk("ready_drop", s_cfg_ready, 0);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_pn_valid) begin
        if (first < 0) first = cyc;
        if (stalled) chk("stall_hold", m_pn_data, held);
        if (rdy) begin
          rx[widx] = m_pn_data;
          chk($sformatf("data[%0d]", widx), m_pn_data, exp_word(base, widx, len));
          chk($sformatf("last[%0d]", widx), m_pn_last, (widx == nw-1));
          if (m_pn_last) nlast++;
          widx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = m_pn_data;
        end
      end
      m_pn_ready = rdy;
    end
    if (cyc >= LIMIT) chk("timeout", cyc, 0);
    if (stop_at < 0) begin
      @(negedge clk);
      m_pn_ready = 1'b1;
      chk("last_count", nlast, 1);
      chk("valid_after_last", m_pn_valid, 0);
      chk("last_clr_after_last", m_pn_last, 0);
      chk("ready_after_last", s_cfg_ready, 1);
      chk("busy_after_last", busy, 0);
    end
  endtask

  initial begin
    int first;
    bit ok;

    // Reset values.
    #2;
    chk("rst_ready", s_cfg_ready, 0);
    chk("rst_valid", m_pn_valid, 0);
    chk("rst_data", m_pn_data, 0);
    chk("rst_last", m_pn_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_rise", s_cfg_ready, 1);

    // len 4, offset 0: words 01, 00.
    build_model(31'h0);
    send_cfg(31'h0, 4, 0);
    collect(2, 4, 0, 0, -1, first);
    chk("t1_first", first, 2);
    chk("t1_w0", rx[0], 2'b01);
    chk("t1_w1", rx[1], 2'b00);

    // offset 30: first word {c31,c30}=10.
    send_cfg(31'h0, 32, 30);
    collect(16, 32, 30, 0, -1, first);
    chk("t2_first", first, 32);
    chk("t2_w0", rx[0], 2'b10);

    // 38.211 Nc=1600 equivalent, 108 bits.
    build_model(31'h1A2B3C4);
    send_cfg(31'h1A2B3C4, 108, 1600);
    collect(54, 108, 1600, 0, -1, first);
    chk("t3_first", first, 1602);
    for (int i = 0; i < 54; i++) rx_ref[i] = rx[i];

    // Same config with random back-pressure.
    send_cfg(31'h1A2B3C4, 108, 1600);
    collect(54, 108, 1600, 1, -1, first);
    ok = 1;
    for (int i = 0; i < 54; i++) if (rx[i] !== rx_ref[i]) ok = 0;
    chk("t4_stream_same", ok, 1);

    // Partial final word.
    send_cfg(31'h1A2B3C4, 5, 0);
    collect(3, 5, 0, 0, -1, first);
    chk("t5_w2_bit1", rx[2][1], 0);
    chk("t5_w2_bit0", rx[2][0], c_seq[4]);

    // Zero length: accepted, nothing emitted, ready stays high.
    send_cfg(31'h1A2B3C4, 0, 0);
    ok = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_pn_valid || !s_cfg_ready || busy) ok = 0;
    end
    chk("t6_zero_len_idle", ok, 1);

    // Reset in the middle of a run, then a clean full run.
    send_cfg(31'h1A2B3C4, 108, 1600);
    collect(54, 108, 1600, 0, 10, first);
    @(negedge clk);
    chk("pre_rst_valid", m_pn_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", m_pn_valid, 0);
    chk("mid_rst_data", m_pn_data, 0);
    chk("mid_rst_last", m_pn_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_cfg_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    send_cfg(31'h1A2B3C4, 108, 1600);
    collect(54, 108, 1600, 0, -1, first);
    chk("t7_first", first, 1602);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pdcch_pn_seq_gen.md
Name: pdcch_pn_seq_gen

Overview:
- Downstream neighbour of the PDCCH controller. Consumes one per-occasion config (C_init, PN sequence length, DMRS offset) over a valid/ready handshake.
- Generates the 38.211 §5.2.1 length-31 Gold sequence c(n): warm-up of NC steps, then skip of dmrsoffset bits, then pnseqlength bits.
- Output is a stream of OUT_W-bit words to the DMRS QPSK mapper.

Parameters:
- OUT_W, 2, bits per output word; c(n) pairs for QPSK. Legal values 1..8.
- NC, 1600, Gold warm-up offset Nc. Set to 0 only in test benches.
- LEN_W, 16, width of the sequence-length field.
- OFS_W, 13, width of the DMRS offset field.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset, in, 1, asynchronous active-low reset: assert asynchronously, deassert synchronously in the integration.
- s_cfg_valid, in, 1, config valid.
- s_cfg_ready, out, 1, config ready.
- s_cfg_cinit, in, 31, C_init; loads x2.
- s_cfg_seqlen, in, LEN_W, number of c(n) bits to emit.
- s_cfg_offset, in, OFS_W, bits discarded after the NC warm-up.
- m_pn_valid, out, 1, output word valid.
- m_pn_ready, in, 1, downstream ready.
- m_pn_data, out, OUT_W, bit i holds c(k+i); the earliest bit is in the LSB.
- m_pn_last, out, 1, marks the final word of the sequence.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (reset=0): state=IDLE, s_cfg_ready=0, m_pn_valid=0, m_pn_data=0, m_pn_last=0, busy=0, all counters and LFSRs 0.
- s_cfg_ready rises on the first clock after reset release.
- LFSRs:
  - x1 initialises to 31'h1; x2 initialises to s_cfg_cinit (bit0 = x2(0)).
  - x1(n+31) = x1(n+3) ^ x1(n).
  - x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n).
  - c = x1(n) ^ x2(n), taken from bit0 of each register after the advance.
- IDLE: s_cfg_ready=1. On valid&&ready:
  - load x1, x2, remaining=s_cfg_seqlen, skip=NC+s_cfg_offset (17-bit counter);
  - drop s_cfg_ready the next cycle.
  - If seqlen==0, stay in IDLE: no output, ready stays 1.
  - Else if skip==0, go to LOAD; else go to WARM.
- WARM: advance both LFSRs by 1 step per cycle and decrement skip. Go to LOAD when skip reaches 0. Duration is exactly NC+offset cycles.
- LOAD (1 cycle):
  - compute the next word from OUT_W combinational steps; register it into m_pn_data;
  - set m_pn_valid=1; set m_pn_last=(remaining<=OUT_W);
  - go to OUT.
- OUT: word held stable while m_pn_valid && !m_pn_ready.
  - On handshake, if last: valid=0, last=0, go to IDLE (ready=1 next cycle).
  - Otherwise load the next word in the same cycle (no bubble); remaining -= OUT_W.
- Final partial word (seqlen not a multiple of OUT_W): unused upper bits are 0; word count = ceil(seqlen/OUT_W).
- Latency: config accept at cycle 0 → m_pn_valid first high at cycle NC+offset+2.
- Throughput: one word per cycle while m_pn_ready=1.
- Config is never accepted while busy. A new config after last is accepted no earlier than 1 cycle after the last handshake.
- Reset mid-sequence: immediate return to reset values; the partial sequence is discarded; no m_pn_last is emitted.
- Arithmetic: remaining is LEN_W bits and never underflows; it saturates at 0 on the last word.

Test Plan:
- NC=0, cinit=0, seqlen=4, offset=0, ready=1 → words 2'b01, 2'b00; last on word 2; valid first at cycle 2.
- NC=0, cinit=0, seqlen=32, offset=30 → first word = {c31,c30} = 2'b10, where c30=0 and c31=1 (x1(31)=x1(3)^x1(0)=1); 16 words total.
- NC=1600, cinit=0x1A2B3C4, seqlen=108, offset=0 → 54 words matching a 38.211 software model bit-exact; valid first at cycle 1602.
- Same config with m_pn_ready toggling randomly (50%) → data stable while stalled; identical word stream; exactly one last.
- seqlen=5, OUT_W=2 → 3 words; word 3 bit1=0; last on word 3. Then seqlen=0 config → accepted, no output, ready stays 1.
- reset pulled low at word 10 of a 54-word run → all outputs 0 asynchronously; after release, a new config produces the correct full sequence from word 1.
